// File: rtl/pa_rvfpm.sv
// Shared FPU-model constants and types for the CORE-V-XIF issue path.
package pa_rvfpm;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned X_NUM_RS      = 3;
  localparam int unsigned X_ID_WIDTH    = 4;
  localparam int unsigned X_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    PENDING   = 2'd1,
    COMMITTED = 2'd2,
    KILLED    = 2'd3
  } x_q_state_e;

  typedef struct packed {
    logic [X_INSTR_WIDTH-1:0]  instr;
    logic [X_ID_WIDTH-1:0]     id;
    logic [X_NUM_RS*XLEN-1:0]  rs;
  } x_q_entry_t;

endpackage

// File: rtl/rvfpm_id_match.sv
// Per-entry ID comparator, qualified by a mask of entry states that may take part.
module rvfpm_id_match
  import pa_rvfpm::*;
#(
  parameter int unsigned Depth   = 4,
  parameter int unsigned IdWidth = 4
) (
  input  x_q_state_e         state_i [Depth],
  input  logic [IdWidth-1:0] id_i    [Depth],
  input  logic [IdWidth-1:0] key_i,
  input  logic [3:0]         qual_i,
  output logic [Depth-1:0]   match_o,
  output logic               any_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < Depth; i++) begin
      // qual_i bit n enables entries whose state encodes to n
      match_o[i] = qual_i[state_i[i]] && (id_i[i] == key_i);
    end
  end

  assign any_o = |match_o;

endmodule

// File: rtl/rvfpm_xif_issue_queue.sv
// In-order issue buffer between the XIF issue/commit interfaces and the FPU execute stage.
module rvfpm_xif_issue_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned XLEN        = pa_rvfpm::XLEN,
  parameter int unsigned X_NUM_RS    = pa_rvfpm::X_NUM_RS,
  parameter int unsigned X_ID_WIDTH  = pa_rvfpm::X_ID_WIDTH
) (
  input  logic                               ck,
  input  logic                               rst,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [31:0]                        issue_instr,
  input  logic [X_ID_WIDTH-1:0]              issue_id,
  input  logic [X_NUM_RS*XLEN-1:0]           issue_rs,
  input  logic                               predec_accept,
  output logic                               issue_accept,
  input  logic                               commit_valid,
  input  logic [X_ID_WIDTH-1:0]              commit_id,
  input  logic                               commit_kill,
  output logic                               disp_valid,
  input  logic                               disp_ready,
  output logic [31:0]                        disp_instr,
  output logic [X_ID_WIDTH-1:0]              disp_id,
  output logic [X_NUM_RS*XLEN-1:0]           disp_rs,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic                               full,
  output logic                               empty,
  output logic                               commit_miss
);
  import pa_rvfpm::*;

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned RsW  = X_NUM_RS * XLEN;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(QUEUE_DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);
  // State masks for the comparator: any live entry, or only PENDING ones
  localparam logic [3:0] QualLive    = 4'b1110;
  localparam logic [3:0] QualPending = 4'b0010;

  x_q_state_e               state_q [QUEUE_DEPTH];
  x_q_state_e               state_d [QUEUE_DEPTH];
  logic [X_INSTR_WIDTH-1:0] instr_q [QUEUE_DEPTH];
  logic [X_ID_WIDTH-1:0]    id_q    [QUEUE_DEPTH];
  logic [RsW-1:0]           rs_q    [QUEUE_DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            commit_miss_q, commit_miss_d;

  logic [QUEUE_DEPTH-1:0] conflict_match, commit_match;
  logic                   id_conflict, commit_hit;
  logic                   push, pop, drop, same_id;
  x_q_state_e             commit_state;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  rvfpm_id_match #(
    .Depth   (QUEUE_DEPTH),
    .IdWidth (X_ID_WIDTH)
  ) u_conflict_match (
    .state_i (state_q),
    .id_i    (id_q),
    .key_i   (issue_id),
    .qual_i  (QualLive),
    .match_o (conflict_match),
    .any_o   (id_conflict)
  );

  rvfpm_id_match #(
    .Depth   (QUEUE_DEPTH),
    .IdWidth (X_ID_WIDTH)
  ) u_commit_match (
    .state_i (state_q),
    .id_i    (id_q),
    .key_i   (commit_id),
    .qual_i  (QualPending),
    .match_o (commit_match),
    .any_o   (commit_hit)
  );

  assign count        = count_q;
  assign full         = (count_q == DepthCnt);
  assign empty        = (count_q == '0);
  assign commit_miss  = commit_miss_q;
  assign issue_accept = predec_accept;
  assign issue_ready  = !rst && !full && !id_conflict;
  assign push         = issue_valid && issue_ready && predec_accept;

  assign disp_valid = (state_q[head_q] == COMMITTED);
  assign disp_instr = instr_q[head_q];
  assign disp_id    = id_q[head_q];
  assign disp_rs    = rs_q[head_q];
  assign pop        = disp_valid && disp_ready;
  assign drop       = (state_q[head_q] == KILLED);

  // A pushed ID can never already be live, so a same-cycle commit targets the new entry
  assign same_id      = commit_valid && push && (commit_id == issue_id);
  assign commit_state = commit_kill ? KILLED : COMMITTED;

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (commit_valid && commit_match[i]) begin
        state_d[i] = commit_state;
      end
    end
    if (pop || drop) begin
      state_d[head_q] = FREE;
    end
    if (push) begin
      state_d[tail_q] = same_id ? commit_state : PENDING;
    end
  end

  always_comb begin
    head_d        = (pop || drop) ? ptr_inc(head_q) : head_q;
    tail_d        = push ? ptr_inc(tail_q) : tail_q;
    count_d       = count_q + CntW'(push) - CntW'(pop || drop);
    commit_miss_d = commit_valid && !commit_hit && !same_id;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        state_q[i] <= FREE;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_miss_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_miss_q <= commit_miss_d;
    end
  end

  // Payload is only observed while its entry is live, so it needs no reset
  always_ff @(posedge ck) begin
    if (push) begin
      instr_q[tail_q] <= issue_instr;
      id_q[tail_q]    <= issue_id;
      rs_q[tail_q]    <= issue_rs;
    end
  end

endmodule

// File: doc/rvfpm_xif_issue_queue.md
Name: rvfpm_xif_issue_queue

Overview:
- Synthesisable, parametrised issue buffer between the CORE-V-XIF issue/commit interfaces and the FPU execute pipeline.
- Captures accepted instructions with their ID and source operands, and tracks commit or kill per ID.
- Releases committed entries to execute in issue order; killed entries are discarded.
- Replaces the fixed, model-internal queue with configurable depth, operand count and ID width.

Parameters:
- QUEUE_DEPTH, 4, number of entries; legal range 1..64; non-power-of-2 allowed.
- XLEN, pa_rvfpm::XLEN, operand width.
- X_NUM_RS, pa_rvfpm::X_NUM_RS, source operands per entry; legal range 2..3.
- X_ID_WIDTH, pa_rvfpm::X_ID_WIDTH, instruction ID width.

Ports:
- ck  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  queue can take the issue request.
- issue_instr  in  32  instruction word.
- issue_id  in  X_ID_WIDTH  instruction ID.
- issue_rs  in  X_NUM_RS*XLEN  source operands; rs[i] at bits [i*XLEN +: XLEN].
- predec_accept  in  1  combinational accept from the predecoder.
- issue_accept  out  1  accept returned to the core.
- commit_valid  in  1  commit transaction valid.
- commit_id  in  X_ID_WIDTH  ID being committed.
- commit_kill  in  1  1 = kill, 0 = commit.
- disp_valid  out  1  head entry is ready for execute.
- disp_ready  in  1  execute takes the head entry.
- disp_instr  out  32  head instruction word.
- disp_id  out  X_ID_WIDTH  head ID.
- disp_rs  out  X_NUM_RS*XLEN  head operands.
- count  out  $clog2(QUEUE_DEPTH+1)  number of live entries.
- full  out  1  count == QUEUE_DEPTH.
- empty  out  1  count == 0.
- commit_miss  out  1  one-cycle pulse: commit_id matched no uncommitted live entry.

Behaviour:
- Clocking and reset:
  - One clock, ck. Reset is synchronous and active-high on rst.
  - Reset clears all entry states, head/tail pointers, count and commit_miss.
  - After reset: empty=1, full=0, issue_ready=0 during the rst cycle and 1 afterwards, disp_valid=0, commit_miss=0.
  - Reset mid-operation drops every entry without dispatching any of them.
- Entry state (2-bit, per entry): FREE, PENDING, COMMITTED, KILLED.
  - FREE -> PENDING on push.
  - PENDING -> COMMITTED on commit.
  - PENDING -> KILLED on kill.
  - COMMITTED -> FREE on dispatch handshake.
  - KILLED -> FREE on head drop.
- Issue:
  - issue_accept = predec_accept, combinational.
  - issue_ready = !full && !id_conflict. id_conflict means a non-FREE entry holds issue_id. Derived from registered state only.
  - Push occurs when issue_valid && issue_ready && predec_accept. The entry is written at tail and tail wraps to 0 after QUEUE_DEPTH-1.
- Commit:
  - On commit_valid, all PENDING entries are searched for commit_id.
  - A match moves to COMMITTED, or to KILLED if commit_kill=1.
  - No match raises commit_miss the next cycle; state is unchanged.
  - A commit in the same cycle as a push of the same ID applies to the newly pushed entry, which is written directly as COMMITTED or KILLED.
- Dispatch (head):
  - disp_* outputs are driven combinationally from the head entry.
  - disp_valid = head is COMMITTED.
  - Pop occurs on disp_valid && disp_ready.
  - A KILLED head is dropped automatically, one per cycle, with disp_valid=0.
  - A PENDING head blocks all younger entries (in-order dispatch).
  - Minimum latency: push and commit in cycle N gives disp_valid in cycle N+1.
- Count:
  - count' = count + push - pop - drop.
  - Push and pop/drop in the same cycle leave count unchanged.
  - Push while full is impossible because issue_ready=0.

Decomposition:
- pa_rvfpm gains:
  - typedef enum logic [1:0] x_q_state_e {FREE, PENDING, COMMITTED, KILLED};
  - typedef struct packed x_q_entry_t {instr, id, rs};
  - localparam X_INSTR_WIDTH = 32.
- One sub-module, rvfpm_id_match: a QUEUE_DEPTH-wide ID comparator with a state qualifier. Instanced twice, for the issue_id conflict check and the commit_id search.

Test Plan:
- Reset, then issue 4 IDs 0..3 with predec_accept=1 and QUEUE_DEPTH=4 -> count=4, full=1, issue_ready=0; a 5th request is not accepted.
- Commit IDs 1 then 0, with disp_ready=1 -> disp_id=0 in the cycle after commit 0, then disp_id=1; ID 1 is never dispatched before ID 0.
- Kill ID 0 while IDs 1 and 2 are committed -> no dispatch for 0; head drops in 1 cycle; disp_id sequence is 1, 2.
- Issue ID 5 while ID 5 is live -> issue_ready=0 until ID 5 dispatches; then the push succeeds.
- Commit ID 7 with no entry for it -> commit_miss=1 for exactly one cycle; count unchanged.
- Assert rst with 3 committed entries and disp_ready=0 -> next cycle empty=1, disp_valid=0, and no dispatch occurs.
